// File: rtl/pattern_sequencer_if.sv
// Bundle of the frame-timing, mode and button inputs and the
// pattern-control outputs shared by the sequencer and its environment.
interface pattern_sequencer_if #(
    parameter int NUM_PATTERNS = 4
) ();
    logic                    next_frame;
    logic                    auto_mode;
    logic                    btn_next;
    logic                    btn_faster;
    logic                    btn_slower;
    logic [NUM_PATTERNS-1:0] pattern_enable;
    logic [2:0]              pattern_sel;
    logic [11:0]             step_size;
    logic                    blanking;

    // Environment side: produces frame strobes and button levels.
    modport master (
        output next_frame, auto_mode, btn_next, btn_faster, btn_slower,
        input  pattern_enable, pattern_sel, step_size, blanking
    );

    // Sequencer side: consumes strobes and buttons, drives pattern control.
    modport slave (
        input  next_frame, auto_mode, btn_next, btn_faster, btn_slower,
        output pattern_enable, pattern_sel, step_size, blanking
    );
endinterface

// File: rtl/pattern_sequencer.sv
// Cycles through NUM_PATTERNS test-pattern generators, inserting black
// frames between patterns, and manages a per-frame step size that the
// operator can raise or lower with buttons. All outputs are registered.
module pattern_sequencer #(
    parameter int          NUM_PATTERNS = 4,
    parameter int          DWELL_FRAMES = 600,
    parameter int          BLANK_FRAMES = 8,
    parameter logic [11:0] STEP_RESET   = 12'h010,
    parameter logic [11:0] STEP_MIN     = 12'h004,
    parameter logic [11:0] STEP_MAX     = 12'h0C0,
    parameter logic [11:0] STEP_INC     = 12'h004
) (
    input  logic                clk,
    input  logic                rst_n,
    pattern_sequencer_if.slave  bus
);

    typedef enum logic {
        RUN   = 1'b0,
        BLANK = 1'b1
    } state_t;

    localparam logic [11:0]             DWELL_LAST = 12'(DWELL_FRAMES - 1);
    localparam logic [7:0]              BLANK_LAST = 8'(BLANK_FRAMES - 1);
    localparam logic [2:0]              SEL_LAST   = 3'(NUM_PATTERNS - 1);
    localparam logic [NUM_PATTERNS-1:0] ONE_HOT0   = NUM_PATTERNS'(1);

    state_t                  state_q,    state_d;
    logic [2:0]              sel_q,      sel_d;
    logic [NUM_PATTERNS-1:0] enable_q,   enable_d;
    logic [11:0]             step_q,     step_d;
    logic                    blank_q,    blank_d;
    logic [11:0]             dwell_q,    dwell_d;
    logic [7:0]              bcnt_q,     bcnt_d;
    logic                    next_req_q, next_req_d;
    logic                    up_req_q,   up_req_d;
    logic                    dn_req_q,   dn_req_d;
    logic                    prev_next_q, prev_fast_q, prev_slow_q;

    logic        next_edge, fast_edge, slow_edge;
    logic        next_pend, up_pend, dn_pend;
    logic [12:0] step_up, step_dn;

    // Rising-edge detect on the already-debounced button levels.
    always_comb begin
        next_edge = bus.btn_next   & ~prev_next_q;
        fast_edge = bus.btn_faster & ~prev_fast_q;
        slow_edge = bus.btn_slower & ~prev_slow_q;
    end

    // Speed arithmetic in 13 bits so overflow/underflow clamp instead of wrap.
    always_comb begin
        step_up = {1'b0, step_q} + {1'b0, STEP_INC};
        step_dn = {1'b0, step_q} - {1'b0, STEP_INC};
    end

    // Next-state, counters, request flags and output values.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        enable_d   = enable_q;
        step_d     = step_q;
        blank_d    = blank_q;
        dwell_d    = dwell_q;
        bcnt_d     = bcnt_q;
        next_req_d = next_req_q;
        up_req_d   = up_req_q;
        dn_req_d   = dn_req_q;

        // An edge arriving with next_frame counts for that same frame.
        next_pend = next_req_q | next_edge;
        up_pend   = up_req_q | fast_edge;
        dn_pend   = dn_req_q | slow_edge;

        // Speed requests are accepted in either state.
        up_req_d = up_pend;
        dn_req_d = dn_pend;

        if (bus.next_frame) begin
            up_req_d = 1'b0;
            dn_req_d = 1'b0;
            if (up_pend && !dn_pend) begin
                step_d = (step_up > {1'b0, STEP_MAX}) ? STEP_MAX : step_up[11:0];
            end else if (dn_pend && !up_pend) begin
                step_d = (step_dn[12] || step_dn < {1'b0, STEP_MIN}) ? STEP_MIN
                                                                    : step_dn[11:0];
            end
        end

        unique case (state_q)
            RUN: begin
                next_req_d = next_pend;
                if (bus.next_frame) begin
                    if (next_pend || (bus.auto_mode && dwell_q == DWELL_LAST)) begin
                        state_d    = BLANK;
                        bcnt_d     = '0;
                        next_req_d = 1'b0;
                        blank_d    = 1'b1;
                        enable_d   = '0;
                    end else if (bus.auto_mode && dwell_q != DWELL_LAST) begin
                        // Counting only while auto_mode is high holds the
                        // dwell position across a manual interlude.
                        dwell_d = dwell_q + 12'd1;
                    end
                end
            end
            BLANK: begin
                // Pattern-advance requests are not latched while blanking.
                next_req_d = 1'b0;
                if (bus.next_frame) begin
                    if (bcnt_q == BLANK_LAST) begin
                        state_d  = RUN;
                        sel_d    = (sel_q == SEL_LAST) ? '0 : sel_q + 3'd1;
                        dwell_d  = '0;
                        blank_d  = 1'b0;
                        enable_d = ONE_HOT0 << sel_d;
                    end else begin
                        bcnt_d = bcnt_q + 8'd1;
                    end
                end
            end
            default: state_d = RUN;
        endcase
    end

    // State register; reset aborts any dwell/blank and drops pending requests.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= RUN;
            sel_q       <= '0;
            enable_q    <= ONE_HOT0;
            step_q      <= STEP_RESET;
            blank_q     <= 1'b0;
            dwell_q     <= '0;
            bcnt_q      <= '0;
            next_req_q  <= 1'b0;
            up_req_q    <= 1'b0;
            dn_req_q    <= 1'b0;
            prev_next_q <= 1'b1;
            prev_fast_q <= 1'b1;
            prev_slow_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            enable_q    <= enable_d;
            step_q      <= step_d;
            blank_q     <= blank_d;
            dwell_q     <= dwell_d;
            bcnt_q      <= bcnt_d;
            next_req_q  <= next_req_d;
            up_req_q    <= up_req_d;
            dn_req_q    <= dn_req_d;
            prev_next_q <= bus.btn_next;
            prev_fast_q <= bus.btn_faster;
            prev_slow_q <= bus.btn_slower;
        end
    end

    // Outputs come straight from flops.
    always_comb begin
        bus.pattern_enable = enable_q;
        bus.pattern_sel    = sel_q;
        bus.step_size      = step_q;
        bus.blanking       = blank_q;
    end

endmodule

// File: tb/tb_pattern_sequencer.sv
// Directed bench for pattern_sequencer with a frame-level reference model
// and a per-cycle output comparison.
module tb_pattern_sequencer;

    localparam int NP = 3;
    localparam int DW = 4;
    localparam int BF = 2;
    localparam int S_RESET = 16;
    localparam int S_MIN   = 4;
    localparam int S_MAX   = 192;
    localparam int S_INC   = 4;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    pattern_sequencer_if #(.NUM_PATTERNS(NP)) bus ();

    pattern_sequencer #(
        .NUM_PATTERNS(NP),
        .DWELL_FRAMES(DW),
        .BLANK_FRAMES(BF)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    bit started;
    bit m_blank;
    int m_sel, m_step, m_frames;
    bit m_next_pending, m_up, m_dn;
    bit last_next, last_fast, last_slow;

    always @(posedge clk) begin
        bit pressed_next, pressed_fast, pressed_slow;
        started = 1'b1;
        if (!rst_n) begin
            m_blank = 0; m_sel = 0; m_step = S_RESET; m_frames = 0;
            m_next_pending = 0; m_up = 0; m_dn = 0;
            last_next = 1; last_fast = 1; last_slow = 1;
        end else begin
            pressed_next = bus.btn_next   && !last_next;
            pressed_fast = bus.btn_faster && !last_fast;
            pressed_slow = bus.btn_slower && !last_slow;
            last_next = bus.btn_next;
            last_fast = bus.btn_faster;
            last_slow = bus.btn_slower;
            if (pressed_fast) m_up = 1;
            if (pressed_slow) m_dn = 1;
            if (pressed_next && !m_blank) m_next_pending = 1;
            if (bus.next_frame) begin
                if (m_up && !m_dn) m_step = (m_step + S_INC > S_MAX) ? S_MAX : m_step + S_INC;
                if (m_dn && !m_up) m_step = (m_step - S_INC < S_MIN) ? S_MIN : m_step - S_INC;
                m_up = 0; m_dn = 0;
                if (!m_blank) begin
                    // m_frames = frames already shown of this pattern in auto mode
                    if (m_next_pending || (bus.auto_mode && m_frames + 1 >= DW)) begin
                        m_blank = 1; m_frames = 0; m_next_pending = 0;
                    end else if (bus.auto_mode) begin
                        m_frames++;
                    end
                end else begin
                    m_frames++;
                    if (m_frames == BF) begin
                        m_blank = 0; m_frames = 0; m_sel = (m_sel + 1) % NP;
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: every cycle, DUT outputs against the model.
    always @(negedge clk) begin
        if (started) begin
            chk("cyc_sel",   32'(bus.pattern_sel),    32'(m_sel));
            chk("cyc_en",    32'(bus.pattern_enable), m_blank ? 32'd0 : (32'd1 << m_sel));
            chk("cyc_step",  32'(bus.step_size),      32'(m_step));
            chk("cyc_blank", 32'(bus.blanking),       32'(m_blank));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic nf, input logic bn, input logic bf, input logic bs);
        bus.next_frame = nf;
        bus.btn_next   = bn;
        bus.btn_faster = bf;
        bus.btn_slower = bs;
        @(posedge clk);
        #2;
    endtask

    task automatic frame();
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        started  = 0;
        rst_n    = 0;
        bus.auto_mode = 0;
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("rst_sel",   32'(bus.pattern_sel), 0);
        chk("rst_en",    32'(bus.pattern_enable), 32'b001);
        chk("rst_step",  32'(bus.step_size), 32'h010);
        chk("rst_blank", 32'(bus.blanking), 0);
        rst_n = 1;

        // Auto advance: 4 frames dwell, 2 blank frames.
        bus.auto_mode = 1;
        repeat (3) frame();
        chk("auto_not_yet", 32'(bus.blanking), 0);
        frame();
        chk("auto_blank", 32'(bus.blanking), 1);
        chk("auto_en0",   32'(bus.pattern_enable), 32'b000);
        frame();
        chk("auto_mid_blank", 32'(bus.blanking), 1);
        frame();
        chk("auto_sel1", 32'(bus.pattern_sel), 1);
        chk("auto_en1",  32'(bus.pattern_enable), 32'b010);
        chk("auto_unbl", 32'(bus.blanking), 0);
        chk("model_sel1", 32'(m_sel), 1);

        // Manual advance; presses while blanking are ignored.
        bus.auto_mode = 0;
        cyc(0, 1, 0, 0);
        cyc(1, 1, 0, 0);
        cyc(0, 0, 0, 0);
        chk("man_blank", 32'(bus.blanking), 1);
        cyc(0, 1, 0, 0);
        cyc(1, 1, 0, 0);
        cyc(0, 0, 0, 0);
        frame();
        chk("man_sel2", 32'(bus.pattern_sel), 2);
        chk("man_run",  32'(bus.blanking), 0);
        frame();
        frame();
        chk("man_no_extra", 32'(bus.pattern_sel), 2);

        // Wrap from the last pattern, with edge coinciding with next_frame.
        cyc(1, 1, 0, 0);
        cyc(0, 0, 0, 0);
        frame();
        frame();
        chk("wrap_sel0", 32'(bus.pattern_sel), 0);
        chk("wrap_en",   32'(bus.pattern_enable), 32'b001);

        // Dwell count holds while auto_mode is low.
        bus.auto_mode = 1;
        frame(); frame();
        bus.auto_mode = 0;
        frame(); frame(); frame();
        chk("hold_run", 32'(bus.blanking), 0);
        bus.auto_mode = 1;
        frame();
        chk("hold_run2", 32'(bus.blanking), 0);
        frame();
        chk("hold_blank", 32'(bus.blanking), 1);
        frame(); frame();
        chk("hold_sel1", 32'(bus.pattern_sel), 1);
        bus.auto_mode = 0;

        // Speed saturation.
        for (int i = 0; i < 60; i++) begin
            cyc(0, 0, 1, 0);
            cyc(1, 0, 0, 0);
        end
        chk("step_max", 32'(bus.step_size), 32'h0C0);
        chk("model_step_max", 32'(m_step), 32'h0C0);
        for (int i = 0; i < 60; i++) begin
            cyc(0, 0, 0, 1);
            cyc(1, 0, 0, 0);
        end
        chk("step_min", 32'(bus.step_size), 32'h004);
        cyc(0, 0, 1, 0);
        cyc(1, 0, 0, 0);
        chk("step_008", 32'(bus.step_size), 32'h008);
        cyc(0, 0, 1, 1);
        cyc(1, 0, 0, 0);
        chk("step_both", 32'(bus.step_size), 32'h008);

        // Speed change waits for next_frame.
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("step_wait", 32'(bus.step_size), 32'h008);
        cyc(1, 0, 0, 0);
        chk("step_00c", 32'(bus.step_size), 32'h00C);

        // Reset mid-dwell with next and faster pending.
        cyc(0, 1, 1, 0);
        cyc(0, 0, 0, 0);
        rst_n = 0;
        cyc(0, 0, 0, 0);
        rst_n = 1;
        frame(); frame();
        chk("rstrun_sel",  32'(bus.pattern_sel), 0);
        chk("rstrun_step", 32'(bus.step_size), 32'h010);
        chk("rstrun_blk",  32'(bus.blanking), 0);

        // Reset mid-blank with faster pending.
        cyc(1, 1, 0, 0);
        cyc(0, 0, 1, 0);
        chk("pre_rst_blank", 32'(bus.blanking), 1);
        rst_n = 0;
        cyc(0, 0, 0, 0);
        chk("rstblk_sel",   32'(bus.pattern_sel), 0);
        chk("rstblk_en",    32'(bus.pattern_enable), 32'b001);
        chk("rstblk_step",  32'(bus.step_size), 32'h010);
        chk("rstblk_blank", 32'(bus.blanking), 0);
        rst_n = 1;
        frame(); frame(); frame();
        chk("post_rst_sel",  32'(bus.pattern_sel), 0);
        chk("post_rst_step", 32'(bus.step_size), 32'h010);

        // Button held through reset gives no edge.
        rst_n = 0;
        cyc(0, 1, 1, 0);
        rst_n = 1;
        cyc(1, 1, 1, 0);
        cyc(0, 1, 1, 0);
        chk("held_no_blank", 32'(bus.blanking), 0);
        chk("held_no_step",  32'(bus.step_size), 32'h010);
        cyc(0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
